// File: rtl/handshake_arbiter_pkg.sv
// Shared definitions for the handshake arbiter: FSM state encoding and
// the default forced-release limit used when HS_ARB_TIMEOUT_EN is defined.
package handshake_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT   = 2'b01,
    ST_RELEASE = 2'b10
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage : handshake_arbiter_pkg

// File: rtl/handshake_arbiter_rr_picker.sv
// Combinational round-robin search: starting one above last_id and wrapping
// modulo N_REQ, return the first requester with its req bit set. The search
// visits last_id itself last, so a lone previous owner wins again.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_id,
  output logic             any,
  output logic [IW-1:0]    winner
);

  logic [IW-1:0] idx_s;

  // Walk the N_REQ positions after last_id and keep the first hit.
  always_comb begin
    any    = 1'b0;
    winner = {IW{1'b0}};
    idx_s  = {IW{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = IW'((int'(last_id) + k) % N_REQ);
      if (!any && req[idx_s]) begin
        any    = 1'b1;
        winner = idx_s;
      end else begin
        // an earlier position already won; keep it
        winner = winner;
      end
    end
  end

endmodule : rr_picker

// File: rtl/handshake_arbiter.sv
// Round-robin owner arbitration for a single shared handshake resource.
// IDLE picks a winner, GRANT forwards the resource handshake to the owner,
// RELEASE spends one cycle recording the owner for the next round.
// Optional macro HS_ARB_TIMEOUT_EN adds an 8-bit GRANT watchdog that forces
// RELEASE after TIMEOUT_CYCLES cycles and pulses timeout for that cycle.
module handshake_arbiter
  import handshake_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           accept,
  output logic [N_REQ-1:0]           done,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       res_request,
  input  logic                       res_accept,
  input  logic                       res_done,
  output logic                       timeout
);

  localparam int IW = $clog2(N_REQ);

  // Configuration sanity: refuse to elaborate outside the supported ranges.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("handshake_arbiter: N_REQ or TIMEOUT_CYCLES out of range");
  end

  arb_state_e    state_r;
  logic [IW-1:0] last_id_r;
  logic [IW-1:0] grant_id_r;
  logic          accepted_r;
  logic          pick_any_s;
  logic [IW-1:0] pick_winner_s;
  logic          grant_exit_s;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .req     (req),
    .last_id (last_id_r),
    .any     (pick_any_s),
    .winner  (pick_winner_s)
  );

  // Normal GRANT exits: resource finished, or owner gave up before acceptance.
  assign grant_exit_s = res_done | (~req[grant_id_r] & ~accepted_r);

`ifdef HS_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] to_cnt_r;
  logic       timeout_r;

  // Arbitration FSM with GRANT watchdog; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      last_id_r  <= IW'(N_REQ - 1);
      grant_id_r <= {IW{1'b0}};
      accepted_r <= 1'b0;
      to_cnt_r   <= 8'd0;
      timeout_r  <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            state_r    <= ST_GRANT;
            grant_id_r <= pick_winner_s;
            accepted_r <= 1'b0;
            to_cnt_r   <= 8'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (grant_exit_s) begin
            state_r    <= ST_RELEASE;
            accepted_r <= 1'b0;
          end else if ((to_cnt_r + 8'd1) == TO_LIMIT) begin
            state_r    <= ST_RELEASE;
            accepted_r <= 1'b0;
            timeout_r  <= 1'b1;
          end else begin
            to_cnt_r <= to_cnt_r + 8'd1;
            if (res_accept) begin
              accepted_r <= 1'b1;
            end else begin
              accepted_r <= accepted_r;
            end
          end
        end
        ST_RELEASE: begin
          last_id_r <= grant_id_r;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          accepted_r <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = timeout_r;
`else
  // Arbitration FSM; GRANT persists until done or abandonment.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      last_id_r  <= IW'(N_REQ - 1);
      grant_id_r <= {IW{1'b0}};
      accepted_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            state_r    <= ST_GRANT;
            grant_id_r <= pick_winner_s;
            accepted_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (grant_exit_s) begin
            state_r    <= ST_RELEASE;
            accepted_r <= 1'b0;
          end else if (res_accept) begin
            accepted_r <= 1'b1;
          end else begin
            accepted_r <= accepted_r;
          end
        end
        ST_RELEASE: begin
          last_id_r <= grant_id_r;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          accepted_r <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign grant_id = grant_id_r;
  assign busy     = (state_r == ST_GRANT) || (state_r == ST_RELEASE);

  // Forward the resource handshake to the owner only while in GRANT; a
  // reset cycle suppresses forwarding so an aborted owner sees no done.
  always_comb begin
    accept      = {N_REQ{1'b0}};
    done        = {N_REQ{1'b0}};
    res_request = 1'b0;
    if ((state_r == ST_GRANT) && !rst) begin
      accept[grant_id_r] = res_accept;
      done[grant_id_r]   = res_done;
      res_request        = req[grant_id_r];
    end else begin
      res_request = 1'b0;
    end
  end

endmodule : handshake_arbiter

// File: tb/tb_handshake_arbiter.sv
// Directed bench for handshake_arbiter with a transaction-level owner model
// compared every cycle, plus hand-computed literal expectations.
// Builds with or without HS_ARB_TIMEOUT_EN (TIMEOUT_CYCLES=4 when defined).
module tb_handshake_arbiter;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int  TO_CYC = 4;
  localparam bit  TO_EN  = 1'b1;
  localparam int  PERSIST_N = 6;
`else
  localparam int  TO_CYC = 16;
  localparam bit  TO_EN  = 1'b0;
  localparam int  PERSIST_N = 100;
`endif
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] accept;
  logic [3:0] done;
  logic [1:0] grant_id;
  logic       busy;
  logic       res_request;
  logic       res_accept = 1'b0;
  logic       res_done = 1'b0;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // model: who owns the resource (-1 none), whether we are in the release cycle
  int m_owner = -1;
  bit m_rel   = 1'b0;
  int m_last  = N - 1;
  bit m_acc   = 1'b0;
  int m_gcyc  = 0;
  bit m_to    = 1'b0;

  handshake_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .accept(accept), .done(done),
    .grant_id(grant_id), .busy(busy), .res_request(res_request),
    .res_accept(res_accept), .res_done(res_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the ownership model and the current inputs.
  task automatic model_compare();
    bit       in_grant;
    bit [3:0] e_acc;
    bit [3:0] e_done;
    bit       e_rr;
    in_grant = (m_owner >= 0) && !m_rel && !rst;
    e_acc = 4'b0000;
    e_done = 4'b0000;
    e_rr = 1'b0;
    if (in_grant) begin
      e_acc[m_owner]  = res_accept;
      e_done[m_owner] = res_done;
      e_rr            = req[m_owner];
    end
    chk("m_busy", {31'd0, busy}, {31'd0, m_owner >= 0});
    if (m_owner >= 0) chk("m_grant_id", {30'd0, grant_id}, m_owner);
    chk("m_res_request", {31'd0, res_request}, {31'd0, e_rr});
    chk("m_accept", {28'd0, accept}, {28'd0, e_acc});
    chk("m_done", {28'd0, done}, {28'd0, e_done});
    chk("m_timeout", {31'd0, timeout}, {31'd0, m_rel && m_to});
  endtask

  // Advance the model by one clock edge using the inputs held this cycle.
  task automatic model_step();
    bit ex;
    if (rst) begin
      m_owner = -1; m_rel = 1'b0; m_last = N - 1; m_acc = 1'b0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && req[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_acc = 1'b0;
          m_gcyc = 0;
        end
      end
    end else if (!m_rel) begin
      m_gcyc++;
      ex = res_done || (!req[m_owner] && !m_acc);
      if (ex) begin
        m_rel = 1'b1; m_to = 1'b0;
      end else if (TO_EN && m_gcyc >= TO_CYC) begin
        m_rel = 1'b1; m_to = 1'b1;
      end
      if (res_accept) m_acc = 1'b1;
    end else begin
      m_last = m_owner; m_owner = -1; m_rel = 1'b0; m_to = 1'b0;
    end
  endtask

  task automatic cycle(input bit do_chk);
    @(negedge clk);
    if (do_chk) model_compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic a, input logic d);
    req = r; res_accept = a; res_done = d;
    #1;
  endtask

  logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  int to_cnt;

  initial begin
    // reset
    rst = 1'b1;
    drive(4'b0000, 1'b0, 1'b0);
    cycle(1'b0);
    cycle(1'b1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_outs", {25'd0, accept, done[2:0]}, 32'd0);
    rst = 1'b0;

    // single requester 2
    drive(4'b0100, 1'b0, 1'b0); chk("s1_idle_busy", {31'd0, busy}, 32'd0); cycle(1'b1);
    drive(4'b0100, 1'b0, 1'b0);
    chk("s1_busy", {31'd0, busy}, 32'd1);
    chk("s1_gid", {30'd0, grant_id}, 32'd2);
    chk("s1_rreq", {31'd0, res_request}, 32'd1);
    chk("s1_acc0", {28'd0, accept}, 32'd0);
    cycle(1'b1);
    cycle(1'b1);
    drive(4'b0100, 1'b1, 1'b0); chk("s1_acc", {28'd0, accept}, 32'h4); cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    drive(4'b0100, 1'b1, 1'b1); chk("s1_done", {28'd0, done}, 32'h4); cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0);
    chk("s1_rel_busy", {31'd0, busy}, 32'd1);
    chk("s1_rel_rreq", {31'd0, res_request}, 32'd0);
    cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0); chk("s1_back_idle", {31'd0, busy}, 32'd0); cycle(1'b1);

    // reset, then round robin with all requesting
    rst = 1'b1; cycle(1'b1); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b0, 1'b0); chk("rr_gap_idle", {31'd0, busy}, 32'd0); cycle(1'b1);
      drive(4'b1111, 1'b1, 1'b0);
      chk("rr_order", {30'd0, grant_id}, {30'd0, order[i]});
      cycle(1'b1);
      drive(4'b1111, 1'b1, 1'b1); chk("rr_done", {28'd0, done}, 32'd1 << order[i]); cycle(1'b1);
      drive(4'b1111, 1'b0, 1'b0); chk("rr_gap_rel", {31'd0, res_request}, 32'd0); cycle(1'b1);
    end

    // abandon by requester 1 before acceptance
    drive(4'b0010, 1'b0, 1'b0); cycle(1'b1);
    drive(4'b0010, 1'b0, 1'b0); chk("ab_gid", {30'd0, grant_id}, 32'd1); cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0); chk("ab_no_done", {28'd0, done}, 32'd0); cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0); chk("ab_rel_busy", {31'd0, busy}, 32'd1); cycle(1'b1);
    drive(4'b1111, 1'b0, 1'b0); cycle(1'b1);
    drive(4'b1111, 1'b1, 1'b0); chk("ab_last_id", {30'd0, grant_id}, 32'd2); cycle(1'b1);
    drive(4'b1111, 1'b1, 1'b1); cycle(1'b1);
    drive(4'b0100, 1'b0, 1'b0); cycle(1'b1);
    drive(4'b0100, 1'b0, 1'b0); cycle(1'b1);
    drive(4'b0100, 1'b0, 1'b0); chk("rewin_gid", {30'd0, grant_id}, 32'd2); cycle(1'b1);

    // done coincides with abandonment
    drive(4'b0000, 1'b0, 1'b1); chk("co_done", {28'd0, done}, 32'h4); cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0);
    chk("co_rel_done", {28'd0, done}, 32'd0);
    chk("co_rel_busy", {31'd0, busy}, 32'd1);
    cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0); chk("co_idle", {31'd0, busy}, 32'd0); cycle(1'b1);

    // accepted but never done: watchdog or persistence
    drive(4'b1001, 1'b0, 1'b0); cycle(1'b1);
    drive(4'b1001, 1'b1, 1'b0); chk("to_gid", {30'd0, grant_id}, 32'd3);
    to_cnt = 0;
    for (int i = 0; i < PERSIST_N; i++) begin
      drive(4'b1001, 1'b1, 1'b0);
      if (timeout === 1'b1) to_cnt++;
      cycle(1'b1);
    end
    drive(4'b1001, 1'b0, 1'b0);
    chk("to_busy", {31'd0, busy}, 32'd1);
    chk("to_pulses", to_cnt, TO_EN ? 32'd1 : 32'd0);
    chk("to_next_gid", {30'd0, grant_id}, TO_EN ? 32'd0 : 32'd3);
    drive(4'b1001, 1'b1, 1'b1); cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0); cycle(1'b1);

    // reset in the middle of GRANT
    drive(4'b0100, 1'b0, 1'b0); cycle(1'b1);
    drive(4'b0100, 1'b1, 1'b0); cycle(1'b1);
    rst = 1'b1;
    drive(4'b1111, 1'b0, 1'b1);
    chk("mr_no_done", {28'd0, done}, 32'd0);
    chk("mr_no_to", {31'd0, timeout}, 32'd0);
    cycle(1'b1);
    rst = 1'b0;
    drive(4'b1111, 1'b0, 1'b0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_gid", {30'd0, grant_id}, 32'd0);
    chk("mr_rreq", {31'd0, res_request}, 32'd0);
    cycle(1'b1);
    drive(4'b1111, 1'b0, 1'b0); chk("mr_winner", {30'd0, grant_id}, 32'd0); cycle(1'b1);
    drive(4'b0000, 1'b0, 1'b0); cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_handshake_arbiter
